// File: rtl/flash_read_arbiter.sv
// Round-robin arbiter sharing one SPI flash read controller between instruction fetch
// (port 0) and data load (port 1), with a one-entry last-read buffer and a read watchdog.
module flash_read_arbiter #(
  parameter int unsigned TIMEOUT  = 1023,
  parameter bit          CACHE_EN = 1'b1
) (
  input  logic        clkout,
  input  logic        rst,
  input  logic        req0_i,
  input  logic [15:0] addr0_i,
  input  logic        req1_i,
  input  logic [15:0] addr1_i,
  input  logic        invalidate_i,
  output logic        ack0_o,
  output logic        ack1_o,
  output logic [31:0] rdata_o,
  output logic        err_o,
  output logic [15:0] fl_addr_o,
  output logic        fl_read_en_o,
  input  logic [31:0] fl_data_i,
  input  logic        fl_valid_i,
  input  logic        fl_busy_i,
  output logic [1:0]  dbg_state_o
);

  // Handshake: a requester raises reqN_i with a stable addrN_i and holds both until it
  // sees the one-cycle ackN_o that qualifies rdata_o/err_o; no grant is made while an ack shows.

  localparam int unsigned CW = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT + 1);
  localparam logic [CW-1:0] TO_VAL     = CW'(TIMEOUT);
  localparam logic [CW-1:0] ISSUE_LAST = CW'(1);

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_ISSUE   = 2'd1,
    S_WAIT    = 2'd2,
    S_RESPOND = 2'd3
  } state_t;

  state_t r_state;
  state_t w_next;

  logic          r_rr;
  logic          r_port;
  logic [15:0]   r_addr;
  logic [CW-1:0] r_tcnt;
  logic [15:0]   r_fl_addr;

  logic          r_buf_valid;
  logic [15:0]   r_buf_addr;
  logic [31:0]   r_buf_data;

  logic [31:0]   r_resp_data;
  logic          r_resp_err;
  logic          r_ack0;
  logic          r_ack1;
  logic [31:0]   r_rdata;
  logic          r_err;

  logic          w_any_req;
  logic          w_ack_prev;
  logic          w_gnt_port;
  logic [15:0]   w_gnt_addr;
  logic          w_hit;

  logic          w_grant;
  logic          w_to_flash;
  logic          w_cap_ok;
  logic          w_cap_err;
  logic          w_respond;
  logic          w_read_en;

  assign w_any_req  = req0_i | req1_i;
  assign w_ack_prev = r_ack0 | r_ack1;
  // With both requesting the rr pointer decides; otherwise the lone requester wins.
  assign w_gnt_port = (req0_i & req1_i) ? r_rr : req1_i;
  assign w_gnt_addr = w_gnt_port ? addr1_i : addr0_i;
  assign w_hit      = CACHE_EN && r_buf_valid && (w_gnt_addr == r_buf_addr) && !invalidate_i;

  always_ff @(posedge clkout) begin
    if (rst) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  always_comb begin
    w_next     = r_state;
    w_grant    = 1'b0;
    w_to_flash = 1'b0;
    w_cap_ok   = 1'b0;
    w_cap_err  = 1'b0;
    w_respond  = 1'b0;
    w_read_en  = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (w_any_req && !w_ack_prev) begin
          if (w_hit) begin
            w_grant = 1'b1;
            w_next  = S_RESPOND;
          end else if (!fl_busy_i) begin
            // A busy controller is still draining a timed-out read: hold off the grant.
            w_grant    = 1'b1;
            w_to_flash = 1'b1;
            w_next     = S_ISSUE;
          end
        end
      end
      S_ISSUE: begin
        // Two-cycle enable so the controller's registered edge detect cannot miss it.
        w_read_en = 1'b1;
        if (r_tcnt == ISSUE_LAST) begin
          w_next = S_WAIT;
        end
      end
      S_WAIT: begin
        if (fl_valid_i) begin
          w_cap_ok = 1'b1;
          w_next   = S_RESPOND;
        end else if (r_tcnt == TO_VAL) begin
          w_cap_err = 1'b1;
          w_next    = S_RESPOND;
        end
      end
      S_RESPOND: begin
        w_respond = 1'b1;
        w_next    = S_IDLE;
      end
      default: begin
        w_next = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clkout) begin
    if (rst) begin
      r_rr      <= 1'b0;
      r_port    <= 1'b0;
      r_addr    <= '0;
      r_fl_addr <= '0;
      r_tcnt    <= '0;
    end else begin
      if (w_grant) begin
        r_port <= w_gnt_port;
        r_addr <= w_gnt_addr;
        r_rr   <= ~w_gnt_port;
      end
      if (w_to_flash) begin
        r_fl_addr <= w_gnt_addr;
        r_tcnt    <= '0;
      end else if (r_state == S_ISSUE || r_state == S_WAIT) begin
        r_tcnt <= r_tcnt + ISSUE_LAST;
      end
    end
  end

  always_ff @(posedge clkout) begin
    if (rst) begin
      r_resp_data <= '0;
      r_resp_err  <= 1'b0;
      r_ack0      <= 1'b0;
      r_ack1      <= 1'b0;
      r_rdata     <= '0;
      r_err       <= 1'b0;
    end else begin
      if (w_grant && !w_to_flash) begin
        r_resp_data <= r_buf_data;
        r_resp_err  <= 1'b0;
      end
      if (w_cap_ok) begin
        r_resp_data <= fl_data_i;
        r_resp_err  <= 1'b0;
      end
      if (w_cap_err) begin
        r_resp_data <= '1;
        r_resp_err  <= 1'b1;
      end
      r_ack0 <= w_respond & ~r_port;
      r_ack1 <= w_respond & r_port;
      if (w_respond) begin
        r_rdata <= r_resp_data;
        r_err   <= r_resp_err;
      end
    end
  end

  // Only good flash data fills the buffer; invalidate beats a same-cycle fill.
  always_ff @(posedge clkout) begin
    if (rst) begin
      r_buf_valid <= 1'b0;
      r_buf_addr  <= '0;
      r_buf_data  <= '0;
    end else begin
      if (invalidate_i) begin
        r_buf_valid <= 1'b0;
      end else if (w_cap_ok) begin
        r_buf_valid <= 1'b1;
      end
      if (w_cap_ok) begin
        r_buf_addr <= r_addr;
        r_buf_data <= fl_data_i;
      end
    end
  end

  assign ack0_o       = r_ack0;
  assign ack1_o       = r_ack1;
  assign rdata_o      = r_rdata;
  assign err_o        = r_err;
  assign fl_addr_o    = r_fl_addr;
  assign fl_read_en_o = w_read_en;
  assign dbg_state_o  = r_state;

endmodule

// File: tb/tb_flash_read_arbiter.sv
// Directed bench for flash_read_arbiter: a small flash controller model, request drivers,
// an ack-order scoreboard and a single check task feeding the summary line.
module tb_flash_read_arbiter;

  localparam int TO = 1023;

  logic        clkout = 1'b0;
  logic        rst = 1'b1;
  logic        req0_i = 1'b0;
  logic [15:0] addr0_i = '0;
  logic        req1_i = 1'b0;
  logic [15:0] addr1_i = '0;
  logic        invalidate_i = 1'b0;
  logic        ack0_o;
  logic        ack1_o;
  logic [31:0] rdata_o;
  logic        err_o;
  logic [15:0] fl_addr_o;
  logic        fl_read_en_o;
  logic [31:0] fl_data_i = '0;
  logic        fl_valid_i = 1'b0;
  logic        fl_busy_i = 1'b0;
  logic [1:0]  dbg_state_o;

  int n_checks = 0;
  int n_errors = 0;
  int cyc = 0;

  flash_read_arbiter #(.TIMEOUT(TO), .CACHE_EN(1'b1)) dut (
    .clkout       (clkout),
    .rst          (rst),
    .req0_i       (req0_i),
    .addr0_i      (addr0_i),
    .req1_i       (req1_i),
    .addr1_i      (addr1_i),
    .invalidate_i (invalidate_i),
    .ack0_o       (ack0_o),
    .ack1_o       (ack1_o),
    .rdata_o      (rdata_o),
    .err_o        (err_o),
    .fl_addr_o    (fl_addr_o),
    .fl_read_en_o (fl_read_en_o),
    .fl_data_i    (fl_data_i),
    .fl_valid_i   (fl_valid_i),
    .fl_busy_i    (fl_busy_i),
    .dbg_state_o  (dbg_state_o)
  );

  // ---------------- clock / reset ----------------
  always #5 clkout = ~clkout;
  always @(posedge clkout) cyc++;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  task automatic reset_dut();
    @(negedge clkout);
    rst = 1'b1;
    repeat (2) @(negedge clkout);
    rst = 1'b0;
  endtask

  // ---------------- checking ----------------
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  // ---------------- flash controller model ----------------
  int          fm_delay = 80;
  bit          fm_stuck = 1'b0;
  int          fm_cur_delay = 0;
  bit          fm_cur_stuck = 1'b0;
  bit          fm_active = 1'b0;
  int          fm_cnt = 0;
  logic        fm_prev_en = 1'b0;
  int          fm_pulses = 0;
  int          fm_en_cycles = 0;
  int          fm_rise_cyc = 0;
  int          fm_stuck_fall = 0;
  logic [15:0] fm_last_addr = '0;
  logic [31:0] fm_word10 = 32'hDEADBEEF;

  function automatic logic [31:0] flash_word(input logic [15:0] a);
    if (a == 16'h0010) return fm_word10;
    return {~a, a};
  endfunction

  always @(negedge clkout) begin
    fl_valid_i = 1'b0;
    if (fl_read_en_o && !fm_prev_en) begin
      fm_active    = 1'b1;
      fm_cnt       = 0;
      fm_pulses++;
      fm_cur_stuck = fm_stuck;
      fm_cur_delay = fm_delay;
      fm_last_addr = fl_addr_o;
      fm_rise_cyc  = cyc;
      fl_busy_i    = 1'b1;
    end else if (fm_active) begin
      fm_cnt++;
      if (fm_cnt >= fm_cur_delay) begin
        fm_active = 1'b0;
        fl_busy_i = 1'b0;
        if (fm_cur_stuck) begin
          fm_stuck_fall = cyc;
        end else begin
          fl_valid_i = 1'b1;
          fl_data_i  = flash_word(fm_last_addr);
        end
      end
    end
    if (fl_read_en_o) fm_en_cycles++;
    fm_prev_en = fl_read_en_o;
  end

  // ---------------- scoreboard ----------------
  logic [0:0] exp_q[$];
  logic [0:0] ack_log[$];
  int         both_cnt = 0;

  always @(negedge clkout) begin
    if (ack0_o && ack1_o) both_cnt++;
    else if (ack0_o) ack_log.push_back(1'b0);
    else if (ack1_o) ack_log.push_back(1'b1);
  end

  task automatic clear_log();
    @(posedge clkout);
    ack_log.delete();
    exp_q.delete();
  endtask

  task automatic check_order(input string tag);
    @(posedge clkout);
    check({tag, "_len"}, ack_log.size(), exp_q.size());
    for (int i = 0; i < exp_q.size() && i < ack_log.size(); i++) begin
      check(tag, 32'(ack_log[i]), 32'(exp_q[i]));
    end
  endtask

  // ---------------- drivers ----------------
  task automatic do_req(input bit port, input logic [15:0] addr, input int max_cyc,
                        output logic [31:0] rd, output logic er, output int lat);
    int  start;
    bit  seen;
    @(negedge clkout);
    if (port) begin req1_i = 1'b1; addr1_i = addr; end
    else      begin req0_i = 1'b1; addr0_i = addr; end
    start = cyc;
    seen  = 1'b0;
    rd    = '0;
    er    = 1'b0;
    lat   = -1;
    for (int i = 0; i < max_cyc && !seen; i++) begin
      @(negedge clkout);
      if (port ? ack1_o : ack0_o) begin
        seen = 1'b1;
        rd   = rdata_o;
        er   = err_o;
        lat  = cyc - start;
      end
    end
    if (port) req1_i = 1'b0;
    else      req0_i = 1'b0;
    check(port ? "ack1_seen" : "ack0_seen", 32'(seen), 1);
  endtask

  // Keeps the request line high across acks, stepping the address after each one.
  task automatic stream(input bit port, input logic [15:0] base, input int n);
    int got;
    @(negedge clkout);
    if (port) begin req1_i = 1'b1; addr1_i = base; end
    else      begin req0_i = 1'b1; addr0_i = base; end
    got = 0;
    for (int i = 0; i < 3000 && got < n; i++) begin
      @(negedge clkout);
      if (port ? ack1_o : ack0_o) begin
        check("stream_data", rdata_o, flash_word(base + 16'(got)));
        got++;
        if (port) addr1_i = base + 16'(got);
        else      addr0_i = base + 16'(got);
      end
    end
    if (port) req1_i = 1'b0;
    else      req0_i = 1'b0;
    check("stream_done", got, n);
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_ack0"},  32'(ack0_o), 0);
    check({tag, "_ack1"},  32'(ack1_o), 0);
    check({tag, "_rdata"}, rdata_o, 0);
    check({tag, "_err"},   32'(err_o), 0);
    check({tag, "_faddr"}, 32'(fl_addr_o), 0);
    check({tag, "_ren"},   32'(fl_read_en_o), 0);
    check({tag, "_state"}, 32'(dbg_state_o), 0);
  endtask

  // ---------------- directed sequence ----------------
  initial begin
    logic [31:0] rd, rd1;
    logic        er, er1;
    int          lat, lat1, p0, e0;

    repeat (3) @(negedge clkout);
    check_all_zero("rst");
    rst = 1'b0;

    // Miss to flash: 80-cycle controller, two-cycle enable, address presented.
    p0 = fm_pulses;
    e0 = fm_en_cycles;
    do_req(1'b0, 16'h0010, 400, rd, er, lat);
    check("t1_rdata", rd, 32'hDEADBEEF);
    check("t1_err", 32'(er), 0);
    check("t1_lat", lat, 80 + 3);
    check("t1_pulses", fm_pulses - p0, 1);
    check("t1_en_cycles", fm_en_cycles - e0, 2);
    check("t1_fl_addr", 32'(fm_last_addr), 32'h0010);

    // Buffer hit from port 1, then invalidate forces a real flash read.
    p0 = fm_pulses;
    do_req(1'b1, 16'h0010, 50, rd, er, lat);
    check("t3_hit_rdata", rd, 32'hDEADBEEF);
    check("t3_hit_err", 32'(er), 0);
    check("t3_hit_lat", lat, 2);
    check("t3_hit_pulses", fm_pulses - p0, 0);
    fm_word10 = 32'hCAFEF00D;
    fm_delay  = 10;
    @(negedge clkout);
    invalidate_i = 1'b1;
    @(negedge clkout);
    invalidate_i = 1'b0;
    p0 = fm_pulses;
    do_req(1'b1, 16'h0010, 200, rd, er, lat);
    check("t3_inv_rdata", rd, 32'hCAFEF00D);
    check("t3_inv_pulses", fm_pulses - p0, 1);
    check("t3_inv_lat", lat, 10 + 3);
    p0 = fm_pulses;
    do_req(1'b0, 16'h0010, 50, rd, er, lat);
    check("t3_refill_rdata", rd, 32'hCAFEF00D);
    check("t3_refill_lat", lat, 2);
    check("t3_refill_pulses", fm_pulses - p0, 0);

    // Simultaneous requests after reset: port 0 first, port 1 right after.
    reset_dut();
    clear_log();
    exp_q.push_back(1'b0);
    exp_q.push_back(1'b1);
    fork
      do_req(1'b0, 16'h0100, 300, rd, er, lat);
      do_req(1'b1, 16'h0200, 300, rd1, er1, lat1);
    join
    check("t2_rdata0", rd, flash_word(16'h0100));
    check("t2_rdata1", rd1, flash_word(16'h0200));
    check("t2_lat0", lat, 10 + 3);
    check("t2_lat1", lat1, 2 * (10 + 3) + 1);
    check_order("t2_order");
    check("t2_both", both_cnt, 0);

    // Both ports streaming: strict alternation.
    fm_delay = 5;
    clear_log();
    for (int i = 0; i < 3; i++) begin
      exp_q.push_back(1'b0);
      exp_q.push_back(1'b1);
    end
    fork
      stream(1'b0, 16'h0500, 3);
      stream(1'b1, 16'h0600, 3);
    join
    check_order("t6_order");
    check("t6_both", both_cnt, 0);

    // Stuck flash: watchdog error, next miss held until busy drops.
    fm_stuck = 1'b1;
    fm_delay = 1100;
    do_req(1'b0, 16'h0300, 1500, rd, er, lat);
    check("t4_err", 32'(er), 1);
    check("t4_rdata", rd, 32'hFFFFFFFF);
    check("t4_lat", lat, TO + 3);
    fm_stuck = 1'b0;
    fm_delay = 5;
    p0 = fm_pulses;
    do_req(1'b0, 16'h0304, 300, rd, er, lat);
    check("t4_next_rdata", rd, flash_word(16'h0304));
    check("t4_next_err", 32'(er), 0);
    check("t4_next_pulses", fm_pulses - p0, 1);
    check("t4_waits_busy", 32'(fm_rise_cyc > fm_stuck_fall), 1);
    p0 = fm_pulses;
    do_req(1'b1, 16'h0300, 300, rd, er, lat);
    check("t4_nofill_pulses", fm_pulses - p0, 1);
    check("t4_nofill_rdata", rd, flash_word(16'h0300));

    // Reset during WAIT: transaction dropped, outputs cleared, then normal service.
    fm_delay = 60;
    clear_log();
    @(negedge clkout);
    req0_i  = 1'b1;
    addr0_i = 16'h0400;
    repeat (20) @(negedge clkout);
    check("t5_in_wait", 32'(dbg_state_o), 2);
    rst    = 1'b1;
    req0_i = 1'b0;
    @(negedge clkout);
    check_all_zero("t5_rst");
    rst = 1'b0;
    repeat (80) @(negedge clkout);
    check_order("t5_no_ack");
    fm_delay = 5;
    do_req(1'b0, 16'h0404, 300, rd, er, lat);
    check("t5_after_rdata", rd, flash_word(16'h0404));
    check("t5_after_err", 32'(er), 0);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
